// File: rtl/pc_fetch_unit.sv
// Multicycle fetch/execute sequencer: holds PC and IR and fetches over a req/ready handshake.
// It also picks the next PC from the controller's PCSrc and halts on an illegal select or a misaligned target.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PCSrc,
    input  logic [31:0]      ImmExt,
    input  logic [31:0]      ALUResult,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      Instr,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] target;
    logic        illegal_sel;

    assign PCPlus4     = PC + 32'd4;
    assign imem_addr   = PC;
    assign Instr       = ir;
    assign opcode      = ir[6:0];
    assign funct3      = ir[14:12];
    assign funct7      = ir[31:25];
    assign illegal_sel = (PCSrc == 2'b11);

    always_comb begin
        target = PCPlus4;
        case (PCSrc)
            2'b01:   target = PC + ImmExt;
            2'b10:   target = {ALUResult[31:1], 1'b0};
            default: target = PCPlus4;
        endcase
    end

    // FETCH with imem_req low only occurs right after reset: it launches the first request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FETCH;
            PC           <= RESET_PC;
            ir           <= 32'h0000_0013;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            retired      <= '0;
        end else begin
            case (state)
                S_FETCH, S_WAIT: begin
                    if (imem_req && imem_ready) begin
                        ir          <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end else begin
                        imem_req <= 1'b1;
                        if (imem_req) state <= S_WAIT;
                    end
                end
                S_EXEC: begin
                    instr_valid <= 1'b0;
                    if (illegal_sel || (target[1:0] != 2'b00)) begin
                        halted       <= 1'b1;
                        misalign_err <= !illegal_sel;
                        state        <= S_HALT;
                    end else begin
                        PC       <= target;
                        retired  <= retired + CNT_W'(1);
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
